// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential 16x16 multiplier.
package mult_pkg;

   localparam int unsigned MULT_WIDTH = 16;
   localparam int unsigned MULT_STEPS = 16;
   localparam int unsigned STEP_W     = $clog2(MULT_STEPS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mult_row_step.sv
// One partial-product row: extend S and X to WIDTH+2 bits, add/subtract/pass,
// emit the low bit and shift the rest down as the next partial sum.
module mult_row_step
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = MULT_WIDTH
) (
   input  logic [WIDTH:0]   s,
   input  logic [WIDTH-1:0] x,
   input  logic             y_bit,
   input  logic             sub,
   input  logic             signed_mode,
   output logic             p_bit,
   output logic [WIDTH:0]   s_next
);

   logic [WIDTH+1:0] se;
   logic [WIDTH+1:0] xe;
   logic [WIDTH+1:0] t;

   always_comb begin
      se = {signed_mode & s[WIDTH], s};
      xe = {{2{signed_mode & x[WIDTH-1]}}, x};
      if (!y_bit) begin
         t = se;
      end else if (sub) begin
         t = se - xe;
      end else begin
         t = se + xe;
      end
      p_bit  = t[0];
      s_next = t[WIDTH+1:1];
   end

endmodule

// File: rtl/seq_mult_16bit.sv
// Iterative multiplier: one partial-product row per clock, start/busy/done handshake.
module seq_mult_16bit
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = MULT_WIDTH,
   parameter int unsigned STEPS = WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   state_t            state;
   state_t            state_nxt;
   logic              accept;
   logic              last;
   logic [STEP_W-1:0] step;
   logic [WIDTH-1:0]  x_reg;
   logic [WIDTH-1:0]  y_reg;
   logic              sm_reg;
   logic [WIDTH:0]    s_reg;
   logic [WIDTH:0]    s_nxt;
   logic [WIDTH-1:0]  lo_reg;
   logic              p_bit;

   assign last = (step == STEP_W'(STEPS - 1));

   // Only the final row in signed mode subtracts (weight of the multiplier sign bit).
   mult_row_step #(.WIDTH(WIDTH)) u_row (
      .s           (s_reg),
      .x           (x_reg),
      .y_bit       (y_reg[step]),
      .sub         (sm_reg & last),
      .signed_mode (sm_reg),
      .p_bit       (p_bit),
      .s_next      (s_nxt)
   );

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      busy      = (state == RUN);
      done      = (state == DONE);
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         step    <= '0;
         x_reg   <= '0;
         y_reg   <= '0;
         sm_reg  <= 1'b0;
         s_reg   <= '0;
         lo_reg  <= '0;
         product <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            x_reg  <= a;
            y_reg  <= b;
            sm_reg <= signed_mode;
            s_reg  <= '0;
            step   <= '0;
         end else if (state == RUN) begin
            // Product bits enter at the top and reach their final position after the last row.
            s_reg  <= s_nxt;
            lo_reg <= {p_bit, lo_reg[WIDTH-1:1]};
            step   <= step + 1'b1;
            if (last) product <= {s_nxt[WIDTH-1:0], p_bit, lo_reg[WIDTH-1:1]};
         end
      end
   end

endmodule
